mem_snapshot_bridge: RTL and testbench



---
 rtl/mem_snapshot_pkg.sv | 21 ++
 rtl/snapshot_buf.sv | 76 +++++++
 rtl/mem_snapshot_bridge.sv | 124 ++++++++++++
 tb/tb_mem_snapshot_bridge.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_snapshot_pkg.sv
// mem_snapshot_pkg: FSM encoding and index-width helpers shared by mem_snapshot_bridge and snapshot_buf
package mem_snapshot_pkg;

    typedef logic [1:0] state_t;

    localparam state_t S_IDLE   = 2'd0;
    localparam state_t S_MEM_WR = 2'd1;
    localparam state_t S_MEM_RD = 2'd2;
    localparam state_t S_ACK    = 2'd3;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

    localparam int SLICE_W = clog2(128 / 32);
    localparam int ENTRY_W = 1;

endpackage

// File: rtl/snapshot_buf.sv
// snapshot_buf: N-slice snapshot storage; entry tag/valid tracking under SNAPSHOT_ENTRY_CHECK_EN
module snapshot_buf
    import mem_snapshot_pkg::*;
#(
    parameter int N  = 4,
    parameter int DW = 32,
    parameter int EW = 1,
    parameter int SW = clog2(N)
) (
    input  logic            clk,
    input  logic            srst,
    input  logic [N-1:0]    we,
    input  logic [DW-1:0]   wr_data,
    input  logic            load,
    input  logic [N*DW-1:0] load_data,
    input  logic [EW-1:0]   entry,
    input  logic [EW-1:0]   load_entry,
    input  logic [SW-1:0]   rd_sel,
    output logic [DW-1:0]   rd_slice,
    output logic [N*DW-1:0] all_data,
    output logic            rd_ok
);

    logic [DW-1:0] slices [N];
    logic          restart;

`ifdef SNAPSHOT_ENTRY_CHECK_EN
    logic [EW-1:0] tag;
    logic          valid;

    assign restart = |we[N-1:1] && entry != tag;
    assign rd_ok   = valid && entry == tag;

    // Tag follows the last full-entry load; a slice-0 write or a partial write to another entry invalidates it
    always_ff @(posedge clk) begin
        if (srst) begin
            tag   <= '0;
            valid <= 1'b0;
        end else if (load) begin
            tag   <= load_entry;
            valid <= 1'b1;
        end else if (we[0]) begin
            valid <= 1'b0;
        end else if (restart) begin
            tag   <= entry;
            valid <= 1'b0;
        end
    end
`else
    logic unused_tag;

    assign restart    = 1'b0;
    assign rd_ok      = 1'b1;
    assign unused_tag = ^{entry, load_entry};
`endif

    // Full-width load wins, then per-slice writes; a restart clears every slice not being written
    always_ff @(posedge clk) begin
        for (int i = 0; i < N; i++)
            if (srst)
                slices[i] <= '0;
            else if (load)
                slices[i] <= load_data[i*DW +: DW];
            else if (we[i])
                slices[i] <= wr_data;
            else if (restart)
                slices[i] <= '0;
    end

    for (genvar g = 0; g < N; g++) begin : g_flat
        assign all_data[g*DW +: DW] = slices[g];
    end

    assign rd_slice = slices[rd_sel];

endmodule

// File: rtl/mem_snapshot_bridge.sv
// mem_snapshot_bridge: narrow-bus to wide-memory bridge with atomic slice-0-triggered snapshots (option: SNAPSHOT_ENTRY_CHECK_EN)
module mem_snapshot_bridge
    import mem_snapshot_pkg::*;
#(
    parameter int ADDR_WIDTH     = 64,
    parameter int DATA_WIDTH     = 32,
    parameter int MEM_ADDR_WIDTH = 1,
    parameter int MEM_DATA_WIDTH = 128
) (
    input  logic                      clk,
    input  logic                      srst,
    input  logic                      req_vld,
    input  logic                      wr_en,
    input  logic                      rd_en,
    input  logic [ADDR_WIDTH-1:0]     addr,
    input  logic [DATA_WIDTH-1:0]     wr_data,
    output logic                      ack_vld,
    output logic [DATA_WIDTH-1:0]     rd_data,
    output logic                      mem_req_vld,
    output logic                      mem_wr_en,
    output logic                      mem_rd_en,
    output logic [MEM_ADDR_WIDTH-1:0] mem_addr,
    output logic [MEM_DATA_WIDTH-1:0] mem_wr_data,
    input  logic                      mem_ack_vld,
    input  logic [MEM_DATA_WIDTH-1:0] mem_rd_data,
    output logic                      snap_err
);

    localparam int N   = MEM_DATA_WIDTH / DATA_WIDTH;
    localparam int LSB = clog2(DATA_WIDTH / 8);
    localparam int SW  = clog2(N);

    state_t                    state;
    logic [SW-1:0]             slice;
    logic [MEM_ADDR_WIDTH-1:0] entry;
    logic                      accept;
    logic                      is_rd;
    logic                      s0;
    logic                      load;
    logic                      rd_ok;
    logic [N-1:0]              we;
    logic [DATA_WIDTH-1:0]     rd_slice;
    logic [MEM_DATA_WIDTH-1:0] all_data;
    logic                      unused_bits;

    assign slice       = addr[LSB +: SW];
    assign entry       = addr[LSB+SW +: MEM_ADDR_WIDTH];
    assign accept      = state == S_IDLE && req_vld;
    assign is_rd       = rd_en && !wr_en;
    assign s0          = slice == '0;
    assign we          = accept && wr_en ? N'(1) << slice : '0;
    assign load        = state == S_MEM_RD && mem_ack_vld;
    assign ack_vld     = state == S_ACK;
    assign unused_bits = ^{addr, all_data[DATA_WIDTH-1:0]};

    snapshot_buf #(
        .N  (N),
        .DW (DATA_WIDTH),
        .EW (MEM_ADDR_WIDTH),
        .SW (SW)
    ) u_buf (
        .clk        (clk),
        .srst       (srst),
        .we         (we),
        .wr_data    (wr_data),
        .load       (load),
        .load_data  (mem_rd_data),
        .entry      (entry),
        .load_entry (mem_addr),
        .rd_sel     (slice),
        .rd_slice   (rd_slice),
        .all_data   (all_data),
        .rd_ok      (rd_ok)
    );

    // Transaction FSM: request pulses and read data last one cycle, address/write word hold until the memory acks
    always_ff @(posedge clk) begin
        if (srst) begin
            state       <= S_IDLE;
            mem_req_vld <= 1'b0;
            mem_wr_en   <= 1'b0;
            mem_rd_en   <= 1'b0;
            mem_addr    <= '0;
            mem_wr_data <= '0;
            rd_data     <= '0;
            snap_err    <= 1'b0;
        end else begin
            mem_req_vld <= 1'b0;
            mem_wr_en   <= 1'b0;
            mem_rd_en   <= 1'b0;
            rd_data     <= '0;
            snap_err    <= 1'b0;
            case (state)
                S_IDLE: if (accept) begin
                    if (wr_en && s0) begin
                        state       <= S_MEM_WR;
                        mem_req_vld <= 1'b1;
                        mem_wr_en   <= 1'b1;
                        mem_addr    <= entry;
                        mem_wr_data <= {all_data[MEM_DATA_WIDTH-1:DATA_WIDTH], wr_data};
                    end else if (is_rd && s0) begin
                        state       <= S_MEM_RD;
                        mem_req_vld <= 1'b1;
                        mem_rd_en   <= 1'b1;
                        mem_addr    <= entry;
                    end else begin
                        state <= S_ACK;
                        if (is_rd) begin
                            rd_data  <= rd_ok ? rd_slice : '0;
                            snap_err <= !rd_ok;
                        end
                    end
                end
                S_MEM_WR: if (mem_ack_vld) state <= S_ACK;
                S_MEM_RD: if (mem_ack_vld) begin
                    state   <= S_ACK;
                    rd_data <= mem_rd_data[DATA_WIDTH-1:0];
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_snapshot_bridge.sv
// tb_mem_snapshot_bridge: directed and randomized self-checking bench for mem_snapshot_bridge
`timescale 1ns/1ps
module tb_mem_snapshot_bridge;

    logic         clk = 1'b0;
    logic         srst = 1'b1;
    logic         req_vld = 1'b0;
    logic         wr_en = 1'b0;
    logic         rd_en = 1'b0;
    logic [63:0]  addr = '0;
    logic [31:0]  wr_data = '0;
    logic         ack_vld;
    logic [31:0]  rd_data;
    logic         mem_req_vld;
    logic         mem_wr_en;
    logic         mem_rd_en;
    logic [0:0]   mem_addr;
    logic [127:0] mem_wr_data;
    logic         mem_ack_vld = 1'b0;
    logic [127:0] mem_rd_data = '0;
    logic         snap_err;

    int checks = 0;
    int failures = 0;
    int ack_delay = 1;
    int req_cyc = 0;
    int ack_cnt = 0;

    logic [127:0] mem_arr [2];
    logic         last_wr = 1'b0;
    logic         last_rd = 1'b0;
    logic [0:0]   last_addr = '0;
    logic [127:0] last_wdata = '0;

    logic [31:0]  sbuf [4];
    logic         mtag;
    logic         mvalid;
    logic [31:0]  got_rd;
    logic         got_err;

    always #5 clk = ~clk;

    mem_snapshot_bridge dut (
        .clk         (clk),
        .srst        (srst),
        .req_vld     (req_vld),
        .wr_en       (wr_en),
        .rd_en       (rd_en),
        .addr        (addr),
        .wr_data     (wr_data),
        .ack_vld     (ack_vld),
        .rd_data     (rd_data),
        .mem_req_vld (mem_req_vld),
        .mem_wr_en   (mem_wr_en),
        .mem_rd_en   (mem_rd_en),
        .mem_addr    (mem_addr),
        .mem_wr_data (mem_wr_data),
        .mem_ack_vld (mem_ack_vld),
        .mem_rd_data (mem_rd_data),
        .snap_err    (snap_err)
    );

    always @(negedge clk) begin
        if (mem_req_vld) req_cyc++;
        if (ack_vld) ack_cnt++;
    end

    initial forever begin
        @(negedge clk);
        if (mem_req_vld) begin
            last_wr    = mem_wr_en;
            last_rd    = mem_rd_en;
            last_addr  = mem_addr;
            last_wdata = mem_wr_data;
            repeat (ack_delay) @(negedge clk);
            mem_ack_vld = 1'b1;
            mem_rd_data = mem_arr[last_addr];
            @(negedge clk);
            mem_ack_vld = 1'b0;
            mem_rd_data = '0;
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int j = 0; j < 4; j++) sbuf[j] = '0;
        mtag   = 1'b0;
        mvalid = 1'b0;
    endtask

    task automatic step(input bit w, input bit r, input logic [63:0] a, input logic [31:0] d, input bit inj);
        int k, e, lat, rq0, ac0, erq, el;
        logic [31:0]  er;
        logic         ee;
        logic [127:0] ewd;
        k   = int'(a[3:2]);
        e   = int'(a[4]);
        er  = '0;
        ee  = 1'b0;
        el  = 1;
        erq = 0;
        ewd = '0;
        if (w) begin
            if (k == 0) begin
                ewd       = {sbuf[3], sbuf[2], sbuf[1], d};
                sbuf[0]   = d;
                mem_arr[e] = ewd;
                erq       = 1;
                el        = ack_delay + 2;
                mvalid    = 1'b0;
            end else begin
`ifdef SNAPSHOT_ENTRY_CHECK_EN
                if (e != int'(mtag)) begin
                    for (int j = 0; j < 4; j++) sbuf[j] = '0;
                    mtag   = e[0];
                    mvalid = 1'b0;
                end
`endif
                sbuf[k] = d;
            end
        end else if (r) begin
            if (k == 0) begin
                for (int j = 0; j < 4; j++) sbuf[j] = mem_arr[e][32*j +: 32];
                er     = sbuf[0];
                erq    = 1;
                el     = ack_delay + 2;
                mtag   = e[0];
                mvalid = 1'b1;
            end else begin
                er = sbuf[k];
`ifdef SNAPSHOT_ENTRY_CHECK_EN
                if (!mvalid || int'(mtag) != e) begin
                    er = '0;
                    ee = 1'b1;
                end
`endif
            end
        end
        rq0 = req_cyc;
        ac0 = ack_cnt;
        @(negedge clk);
        req_vld = 1'b1;
        wr_en   = w;
        rd_en   = r;
        addr    = a;
        wr_data = d;
        @(negedge clk);
        req_vld = 1'b0;
        wr_en   = 1'b0;
        rd_en   = 1'b0;
        lat     = 1;
        if (inj) begin
            req_vld = 1'b1;
            wr_en   = 1'b1;
            addr    = 64'h14;
            wr_data = 32'hBAD0BAD0;
        end
        while (!ack_vld && lat < 40) begin
            @(negedge clk);
            req_vld = 1'b0;
            wr_en   = 1'b0;
            lat++;
        end
        got_rd  = rd_data;
        got_err = snap_err;
        chk("rd_data", rd_data, er);
        chk("snap_err", snap_err, ee);
        chk("ack_latency", lat, el);
        @(negedge clk);
        chk("ack_count", ack_cnt - ac0, 1);
        chk("rd_data_idle", rd_data, 0);
        chk("mem_req_cycles", req_cyc - rq0, erq);
        if (erq != 0) begin
            chk("mem_addr", last_addr, e);
            chk("mem_wr_en", last_wr, w);
            chk("mem_rd_en", last_rd, !w);
            if (w) chk("mem_wr_data", last_wdata, ewd);
        end
    endtask

    initial begin
        int ac0, rq0;
        mem_arr[0] = {$urandom, $urandom, $urandom, $urandom};
        mem_arr[1] = {$urandom, $urandom, $urandom, $urandom};
        model_reset();
        repeat (3) @(negedge clk);
        srst = 1'b0;
        chk("rst_ack_vld", ack_vld, 0);
        chk("rst_rd_data", rd_data, 0);
        chk("rst_mem_req_vld", mem_req_vld, 0);
        chk("rst_mem_wr_en", mem_wr_en, 0);
        chk("rst_mem_rd_en", mem_rd_en, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wr_data", mem_wr_data, 0);
        chk("rst_snap_err", snap_err, 0);

        step(0, 1, 64'h04, '0, 0);
        ack_delay = 1;
        step(1, 0, 64'h1C, 32'h33333333, 0);
        step(1, 0, 64'h18, 32'h22222222, 0);
        step(1, 0, 64'h14, 32'h11111111, 0);
        step(1, 0, 64'h10, 32'h00000000, 0);
        chk("plan_wdata", last_wdata, 128'h33333333_22222222_11111111_00000000);
        chk("plan_waddr", last_addr, 1);

        mem_arr[0] = 128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA;
        ack_delay  = 2;
        step(0, 1, 64'h00, '0, 0);
        chk("plan_rd0", got_rd, 32'hAAAAAAAA);
        mem_arr[0] = '1;
        step(0, 1, 64'h04, '0, 0);
        chk("plan_rd1", got_rd, 32'hBBBBBBBB);
        step(0, 1, 64'h0C, '0, 0);
        chk("plan_rd3", got_rd, 32'hDDDDDDDD);
        step(0, 1, 64'h14, '0, 0);
`ifdef SNAPSHOT_ENTRY_CHECK_EN
        chk("plan_tag_rd", got_rd, 0);
        chk("plan_tag_err", got_err, 1);
`else
        chk("plan_notag_rd", got_rd, 32'hBBBBBBBB);
        chk("plan_notag_err", got_err, 0);
`endif

        step(1, 1, 64'h08, 32'h5A5A5A5A, 0);
        step(0, 1, 64'h08, '0, 0);
        ack_delay = 3;
        step(1, 0, 64'h10, 32'h0F0F0F0F, 1);
        step(0, 1, 64'h14, '0, 0);
        step(0, 0, 64'h0C, 32'h12345678, 0);

        ack_delay = 4;
        ac0 = ack_cnt;
        rq0 = req_cyc;
        @(negedge clk);
        req_vld = 1'b1;
        rd_en   = 1'b1;
        addr    = 64'h00;
        @(negedge clk);
        req_vld = 1'b0;
        rd_en   = 1'b0;
        @(negedge clk);
        srst = 1'b1;
        @(negedge clk);
        srst = 1'b0;
        model_reset();
        repeat (8) @(negedge clk);
        chk("srst_no_ack", ack_cnt - ac0, 0);
        chk("srst_one_req", req_cyc - rq0, 1);
        chk("srst_mem_req_vld", mem_req_vld, 0);
        ack_delay = 1;
        step(0, 1, 64'h04, '0, 0);
        step(0, 1, 64'h08, '0, 0);
        step(0, 1, 64'h0C, '0, 0);
        step(0, 1, 64'h10, '0, 0);

        for (int i = 0; i < 60; i++) begin
            ack_delay = int'($urandom_range(1, 3));
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), {$urandom, $urandom}, $urandom, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
